// File: rtl/max7219_if_arbiter.sv
// Two-requester round-robin arbiter sharing one max7219_if serializer; a grant is held for a whole frame.
// Optional forced release of an idle owner when compiled with MAX7219_ARB_TIMEOUT_EN.
module max7219_if_arbiter #(
    parameter int G_DATA_WIDTH = 16,
    parameter int G_TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req0,
    input  logic                    i_req1,
    input  logic                    i_start0,
    input  logic                    i_start1,
    input  logic [G_DATA_WIDTH-1:0] i_data0,
    input  logic [G_DATA_WIDTH-1:0] i_data1,
    input  logic                    i_en_load0,
    input  logic                    i_en_load1,
    output logic                    o_grant0,
    output logic                    o_grant1,
    output logic                    o_done0,
    output logic                    o_done1,
    output logic                    o_max7219_if_start,
    output logic                    o_max7219_if_en_load,
    output logic [G_DATA_WIDTH-1:0] o_max7219_if_data,
    input  logic                    i_max7219_if_done,
    output logic                    o_busy,
    output logic                    o_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT_DONE} state_t;

    state_t                  state, state_nxt;
    logic                    owner, owner_nxt;
    logic                    last, last_nxt;
    logic [G_DATA_WIDTH-1:0] data_nxt;
    logic                    en_load_nxt;
    logic                    start_nxt;
    logic                    done0_nxt, done1_nxt;
    logic                    timeout_nxt;
    logic                    expired;

    logic                    own_req, own_start, own_en_load;
    logic [G_DATA_WIDTH-1:0] own_data;

    // Only the current owner's signals are ever looked at; the other requester is muted.
    assign own_req     = owner ? i_req1     : i_req0;
    assign own_start   = owner ? i_start1   : i_start0;
    assign own_en_load = owner ? i_en_load1 : i_en_load0;
    assign own_data    = owner ? i_data1    : i_data0;

    assign o_busy   = (state != S_IDLE);
    assign o_grant0 = o_busy && !owner;
    assign o_grant1 = o_busy &&  owner;

`ifdef MAX7219_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(G_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    // Any cycle outside S_GRANT (including after an accepted start) leaves the counter cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state != S_GRANT)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign expired = (state == S_GRANT) && (cnt == CNT_W'(G_TIMEOUT - 1));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            owner                <= 1'b0;
            last                 <= 1'b1;
            o_max7219_if_data    <= '0;
            o_max7219_if_en_load <= 1'b0;
            o_max7219_if_start   <= 1'b0;
            o_done0              <= 1'b0;
            o_done1              <= 1'b0;
            o_timeout            <= 1'b0;
        end else begin
            state                <= state_nxt;
            owner                <= owner_nxt;
            last                 <= last_nxt;
            o_max7219_if_data    <= data_nxt;
            o_max7219_if_en_load <= en_load_nxt;
            o_max7219_if_start   <= start_nxt;
            o_done0              <= done0_nxt;
            o_done1              <= done1_nxt;
            o_timeout            <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last;
        data_nxt    = o_max7219_if_data;
        en_load_nxt = o_max7219_if_en_load;
        start_nxt   = 1'b0;
        done0_nxt   = 1'b0;
        done1_nxt   = 1'b0;
        timeout_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    state_nxt = S_GRANT;
                    // On a tie the requester served least recently wins.
                    owner_nxt = (i_req0 && i_req1) ? !last : i_req1;
                end
            end
            S_GRANT: begin
                // A start wins over both a dropped request and an expiring timeout.
                if (own_start) begin
                    data_nxt    = own_data;
                    en_load_nxt = own_en_load;
                    start_nxt   = 1'b1;
                    state_nxt   = S_WAIT_DONE;
                end else if (!own_req) begin
                    state_nxt = S_IDLE;
                    last_nxt  = owner;
                end else if (expired) begin
                    state_nxt   = S_IDLE;
                    last_nxt    = owner;
                    timeout_nxt = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (i_max7219_if_done) begin
                    done0_nxt = !owner;
                    done1_nxt = owner;
                    if (o_max7219_if_en_load) begin
                        state_nxt = S_IDLE;
                        last_nxt  = owner;
                    end else begin
                        state_nxt = S_GRANT;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_max7219_if_arbiter.sv
// Directed bench for max7219_if_arbiter: word scoreboard on the serializer side plus per-step assertions.
module tb_max7219_if_arbiter;

    localparam int DW  = 16;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req0, i_req1, i_start0, i_start1;
    logic [DW-1:0] i_data0, i_data1;
    logic          i_en_load0, i_en_load1;
    logic          o_grant0, o_grant1, o_done0, o_done1;
    logic          o_max7219_if_start, o_max7219_if_en_load;
    logic [DW-1:0] o_max7219_if_data;
    logic          i_max7219_if_done;
    logic          o_busy, o_timeout;

    int checks = 0;
    int errors = 0;
    logic [DW:0] sb[$];

    max7219_if_arbiter #(.G_DATA_WIDTH(DW), .G_TIMEOUT(TMO)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_req0              (i_req0),
        .i_req1              (i_req1),
        .i_start0            (i_start0),
        .i_start1            (i_start1),
        .i_data0             (i_data0),
        .i_data1             (i_data1),
        .i_en_load0          (i_en_load0),
        .i_en_load1          (i_en_load1),
        .o_grant0            (o_grant0),
        .o_grant1            (o_grant1),
        .o_done0             (o_done0),
        .o_done1             (o_done1),
        .o_max7219_if_start  (o_max7219_if_start),
        .o_max7219_if_en_load(o_max7219_if_en_load),
        .o_max7219_if_data   (o_max7219_if_data),
        .i_max7219_if_done   (i_max7219_if_done),
        .o_busy              (o_busy),
        .o_timeout           (o_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Serializer-side scoreboard: every start must match the oldest word pushed by the stimulus.
    always @(negedge clk) begin
        logic [DW:0] exp;
        if (rst_n === 1'b1) begin
            check("grant_exclusive", {31'd0, o_grant0 & o_grant1}, 32'd0);
            if (o_max7219_if_start) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_start: observed data=%0h expected no start", o_max7219_if_data);
                end
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check("if_data", {16'd0, o_max7219_if_data}, {16'd0, exp[DW-1:0]});
                    check("if_en_load", {31'd0, o_max7219_if_en_load}, {31'd0, exp[DW]});
                end
            end
        end
    end

    // One word from requester r: start, serializer busy for 'delay' cycles, done, check o_done.
    task automatic send_word(input int r, input logic [DW-1:0] d, input logic el, input int delay);
        if (r == 0) begin
            i_start0 = 1'b1; i_data0 = d; i_en_load0 = el;
        end else begin
            i_start1 = 1'b1; i_data1 = d; i_en_load1 = el;
        end
        sb.push_back({el, d});
        tick();
        i_start0 = 1'b0;
        i_start1 = 1'b0;
        check("if_start_pulse", {31'd0, o_max7219_if_start}, 32'd1);
        repeat (delay - 1) tick();
        check("data_stable", {16'd0, o_max7219_if_data}, {16'd0, d});
        i_max7219_if_done = 1'b1;
        tick();
        i_max7219_if_done = 1'b0;
        check("done_owner", {30'd0, o_done1, o_done0}, (r == 0) ? 32'd1 : 32'd2);
    endtask

    initial begin
        rst_n = 1'b0;
        i_req0 = 0; i_req1 = 0; i_start0 = 0; i_start1 = 0;
        i_data0 = '0; i_data1 = '0; i_en_load0 = 0; i_en_load1 = 0;
        i_max7219_if_done = 0;

        // Reset values
        repeat (5) tick();
        check("rst_grants", {30'd0, o_grant1, o_grant0}, 32'd0);
        check("rst_dones", {30'd0, o_done1, o_done0}, 32'd0);
        check("rst_start", {31'd0, o_max7219_if_start}, 32'd0);
        check("rst_en_load", {31'd0, o_max7219_if_en_load}, 32'd0);
        check("rst_data", {16'd0, o_max7219_if_data}, 32'd0);
        check("rst_busy_timeout", {30'd0, o_busy, o_timeout}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_no_grant", {30'd0, o_grant1, o_grant0}, 32'd0);
        i_req0 = 1'b1;
        tick();
        check("grant0_latency", {30'd0, o_grant1, o_grant0}, 32'd1);
        check("busy_granted", {31'd0, o_busy}, 32'd1);

        // Single three-word frame
        send_word(0, 16'h0101, 1'b0, 40);
        check("mid_frame_grant", {30'd0, o_grant1, o_grant0}, 32'd1);
        send_word(0, 16'h0202, 1'b0, 40);
        send_word(0, 16'h0303, 1'b1, 40);
        check("frame_end_release", {30'd0, o_grant1, o_grant0}, 32'd0);
        check("frame_end_idle", {31'd0, o_busy}, 32'd0);
        i_req0 = 1'b0;
        tick();
        check("stays_idle", {30'd0, o_grant1, o_grant0}, 32'd0);

        // Contention from reset, with foreign starts along the way
        rst_n = 1'b0;
        i_req0 = 1'b1; i_req1 = 1'b1;
        repeat (5) tick();
        rst_n = 1'b1;
        tick();
        check("tie_first_req0", {30'd0, o_grant1, o_grant0}, 32'd1);
        send_word(0, 16'h1111, 1'b0, 5);
        i_start1 = 1'b1; i_data1 = 16'hFFFF; i_en_load1 = 1'b1;
        tick();
        i_start1 = 1'b0;
        check("foreign_no_start", {31'd0, o_max7219_if_start}, 32'd0);
        check("foreign_no_capture", {16'd0, o_max7219_if_data}, 32'h1111);
        check("foreign_en_load", {31'd0, o_max7219_if_en_load}, 32'd0);
        i_start0 = 1'b1; i_data0 = 16'h3333; i_en_load0 = 1'b1;
        sb.push_back({1'b1, 16'h3333});
        tick();
        i_start0 = 1'b0;
        check("last_word_start", {31'd0, o_max7219_if_start}, 32'd1);
        i_start1 = 1'b1; i_data1 = 16'hFFFF; i_en_load1 = 1'b0;
        tick();
        i_start1 = 1'b0;
        check("foreign_wait_data", {16'd0, o_max7219_if_data}, 32'h3333);
        repeat (3) tick();
        i_max7219_if_done = 1'b1;
        tick();
        i_max7219_if_done = 1'b0;
        check("final_done0", {30'd0, o_done1, o_done0}, 32'd1);
        check("grant_drop_n1", {30'd0, o_grant1, o_grant0}, 32'd0);
        tick();
        check("grant1_n2", {30'd0, o_grant1, o_grant0}, 32'd2);
        send_word(1, 16'hA5A5, 1'b1, 5);
        check("req1_release", {30'd0, o_grant1, o_grant0}, 32'd0);
        tick();
        check("second_tie_req0", {30'd0, o_grant1, o_grant0}, 32'd1);

        // Early release: owner drops its request while a non-last word is in flight
        i_start0 = 1'b1; i_data0 = 16'h4444; i_en_load0 = 1'b0;
        sb.push_back({1'b0, 16'h4444});
        tick();
        i_start0 = 1'b0;
        i_req0 = 1'b0;
        repeat (4) tick();
        check("early_keep_grant", {30'd0, o_grant1, o_grant0}, 32'd1);
        i_max7219_if_done = 1'b1;
        tick();
        i_max7219_if_done = 1'b0;
        check("early_done0", {30'd0, o_done1, o_done0}, 32'd1);
        check("early_still_owner", {30'd0, o_grant1, o_grant0}, 32'd1);
        tick();
        check("early_released", {30'd0, o_grant1, o_grant0}, 32'd0);
        tick();
        check("early_req1_granted", {30'd0, o_grant1, o_grant0}, 32'd2);
        i_req1 = 1'b0;
        tick();
        check("req1_drop_release", {30'd0, o_grant1, o_grant0}, 32'd0);

        // Idle owner: forced release with the timeout build, indefinite hold without it
        i_req0 = 1'b1;
        tick();
        check("tmo_grant0", {30'd0, o_grant1, o_grant0}, 32'd1);
        i_req1 = 1'b1;
`ifdef MAX7219_ARB_TIMEOUT_EN
        repeat (TMO - 1) tick();
        check("tmo_not_yet", {30'd0, o_grant0, o_timeout}, 32'd2);
        tick();
        check("tmo_pulse", {31'd0, o_timeout}, 32'd1);
        check("tmo_grant_low", {30'd0, o_grant1, o_grant0}, 32'd0);
        tick();
        check("tmo_pulse_end", {31'd0, o_timeout}, 32'd0);
        check("tmo_req1_next", {30'd0, o_grant1, o_grant0}, 32'd2);
`else
        repeat (TMO + 4) tick();
        check("hold_grant0", {30'd0, o_grant1, o_grant0}, 32'd1);
        check("no_timeout", {31'd0, o_timeout}, 32'd0);
`endif
        i_req0 = 1'b0; i_req1 = 1'b0;
        repeat (2) tick();

        // Asynchronous reset in the middle of a word
        i_req0 = 1'b1;
        tick();
        i_start0 = 1'b1; i_data0 = 16'h5555; i_en_load0 = 1'b1;
        sb.push_back({1'b1, 16'h5555});
        tick();
        i_start0 = 1'b0;
        tick();
        check("pre_reset_busy", {31'd0, o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", {30'd0, o_grant1, o_grant0}, 32'd0);
        check("async_rst_data", {15'd0, o_max7219_if_en_load, o_max7219_if_data}, 32'd0);
        check("async_rst_busy", {31'd0, o_busy}, 32'd0);
        i_req0 = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
